pe_mac: RTL and testbench
=========================

// Module: pe_mac
// PURPOSE
//  Signed multiply-accumulate processing element. Accumulates a stream of weight/activation
//  pairs into a dot product, then requantises it (round, arithmetic shift, saturate) to OUT_WIDTH.
//  Valid/ready handshakes on both sides with output backpressure. Building block for the
//  systolic/vector compute array; replaces the unsigned single-multiply PE.
// PARAMETERS
//  DATA_WIDTH  8   width of w and x (two's complement)
//  ACC_WIDTH   32  accumulator width; must be >= 2*DATA_WIDTH
//  OUT_WIDTH   8   width of requantised result y; must be <= ACC_WIDTH
//  SHIFT_W     5   width of shift input; must be >= $clog2(ACC_WIDTH)
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst        in   1           asynchronous, active-high reset
//  clear      in   1           synchronous flush: drops all in-flight and held data
//  in_valid   in   1           beat on w/x/in_last is valid
//  in_ready   out  1           PE accepts a beat; beat transfers when in_valid & in_ready
//  w          in   DATA_WIDTH  signed weight
//  x          in   DATA_WIDTH  signed activation
//  in_last    in   1           final beat of the current dot product
//  shift      in   SHIFT_W     requant right-shift; sampled with the in_last beat
//  out_valid  out  1           y/acc_out/ovf hold a completed result
//  out_ready  in   1           consumer accepts; result transfers when out_valid & out_ready
//  y          out  OUT_WIDTH   signed saturated, rounded result
//  acc_out    out  ACC_WIDTH   raw final accumulator value of the result held on y
//  ovf        out  1           accumulator saturated at least once in this dot product
// BEHAVIOUR
//  - Reset: out_valid=0, y=0, acc_out=0, ovf=0, accumulator=0, pipe valids=0, FSM=IDLE.
//    in_ready reads 1 once rst deasserts. Reset mid-dot-product discards all partial results.
//  - stall = out_valid & ~out_ready. in_ready = ~stall. On stall, every stage holds.
//  - Stage 1 (edge of accept): p = signed(w)*signed(x), 2*DATA_WIDTH bits, registered with last/shift.
//  - Stage 2 (next unstalled edge): acc_next = sat_ACC(acc + sext(p)).
//    If the sum leaves the ACC_WIDTH signed range, clamp to max/min and set sticky ovf_int.
//  - On a stage-2 last beat: y <= sat_OUT((acc_next + rnd) >>> shift), where rnd = 1<<(shift-1)
//    if shift>0, else 0. The round add is done at ACC_WIDTH+1 bits (no wrap).
//    Also acc_out <= acc_next, ovf <= ovf_int | overflow on this beat, out_valid <= 1.
//    Accumulator and ovf_int clear to 0 in the same edge, so the next beat starts a fresh sum.
//  - Latency: last beat accepted at edge E0 -> out_valid high after edge E0+2 (no stall).
//    Throughput is 1 beat/clk. Back-to-back dot products have no bubble.
//  - Output: y/acc_out/ovf/out_valid stay stable while out_valid & ~out_ready.
//    out_valid drops on the transfer edge unless a new result loads on the same edge; then it stays 1.
//  - FSM: IDLE (acc empty, no beats in flight) -> ACCUM on first accept.
//    ACCUM -> IDLE when the last beat leaves stage 2 and out_ready=1 or out_valid was not held.
//    ACCUM -> HOLD when the result loads while out_ready=0 at that point.
//    HOLD -> IDLE/ACCUM on out transfer.
//  - in_last on the first beat is legal: a single-product result.
//  - clear has priority over everything, including a simultaneous in or out transfer.
//    Next edge: accumulator=0, pipe valids=0, out_valid=0, ovf=0, FSM=IDLE.
//    y and acc_out are not cleared.
//  - shift >= ACC_WIDTH yields 0 or -1 before saturation; no X propagation.
// TESTING
//  1 rst pulse mid-ACCUM (2 beats in) -> all outputs 0. A new 1-beat w=2,x=3 then gives y=6.
//  2 w={1,2,3,4}, x={5,6,7,8}, last on 4th, shift=0, out_ready=1 -> y=70, acc_out=70,
//    out_valid 2 clk after last accept, ovf=0.
//  3 Single beat w=-128,x=-128: shift=7 -> acc_out=16384, y=127 (sat); shift=8 -> y=64.
//    w=3,x=1,shift=1 -> y=2; w=-3,x=1,shift=1 -> y=-1.
//  4 out_ready=0 for 5 clk with result y=70 held and in_valid=1 -> in_ready=0, outputs stable,
//    no beats lost. Release -> the following dot product {2}*{-4} yields y=-8.
//  5 ACC_WIDTH=16: 3 beats of 127*127 -> acc_out=32767, ovf=1, y=127 at shift=8.
//    The next dot product reports ovf=0.
//  6 clear asserted with the last beat in stage 1 and out_valid=1 -> next clk out_valid=0,
//    no result emerges. A following w=1,x=1 gives y=1.

Source files
------------

// File: rtl/pe_mac.sv
// Signed multiply-accumulate PE: three-stage pipe (product, accumulate, requantise) with
// valid/ready on both sides; a held output result freezes every stage.
module pe_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic                  in_last,
  input  logic [SHIFT_W-1:0]    shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  y,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic signed [ACC_WIDTH:0] OMAX = (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] OMIN = -OMAX - 1;

  function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH:0] v);
    if (v > OMAX) return OMAX[OUT_WIDTH-1:0];
    if (v < OMIN) return OMIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  // Round-half-up then arithmetic shift, carried one bit wider so the round add cannot wrap.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic [SHIFT_W-1:0] sh);
    logic signed [ACC_WIDTH:0] e;
    logic signed [ACC_WIDTH:0] r;
    e = {a[ACC_WIDTH-1], a};
    r = '0;
    if (sh != '0 && int'(sh) <= ACC_WIDTH) r = (ACC_WIDTH+1)'(1) << (sh - 1'b1);
    e = e + r;
    e = e >>> sh;
    return sat_out(e);
  endfunction

  logic                          stall, accept, more;
  logic signed [2*DATA_WIDTH-1:0] prod_p0;
  logic signed [2*DATA_WIDTH-1:0] p_p1;
  logic                          vld_p1, last_p1;
  logic [SHIFT_W-1:0]            shift_p1;
  logic signed [ACC_WIDTH:0]     sum_p1;
  logic signed [ACC_WIDTH-1:0]   acc_next_p1;
  logic                          ov_p1;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic                          ovf_int_q, act_q;
  logic                          vld_p2, ovf_p2;
  logic signed [ACC_WIDTH-1:0]   acc_p2;
  logic [SHIFT_W-1:0]            shift_p2;
  logic                          out_valid_q, ovf_q;
  logic [OUT_WIDTH-1:0]          y_q;
  logic [ACC_WIDTH-1:0]          acc_out_q;
  state_t                        state_q, state_d;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Stage 0 -> 1: signed product
  assign prod_p0 = $signed(w) * $signed(x);

  // Stage 1 -> 2: saturating accumulate
  assign sum_p1 = $signed({acc_q[ACC_WIDTH-1], acc_q})
                + $signed({{(ACC_WIDTH+1-2*DATA_WIDTH){p_p1[2*DATA_WIDTH-1]}}, p_p1});
  assign acc_next_p1 = sat_acc(sum_p1);
  assign ov_p1       = sum_p1[ACC_WIDTH] ^ sum_p1[ACC_WIDTH-1];

  // More work still pending behind the result that is about to load.
  assign more = accept | vld_p1 | act_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCUM;
      ACCUM:   if (vld_p2 && !more) state_d = out_ready ? IDLE : HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = more ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      acc_q       <= '0;
      ovf_int_q   <= 1'b0;
      act_q       <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
    end else if (clear) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      acc_q       <= '0;
      ovf_int_q   <= 1'b0;
      act_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
    end else if (!stall) begin
      vld_p1  <= accept;
      vld_p2  <= vld_p1 & last_p1;
      state_q <= state_d;
      if (vld_p1) begin
        if (last_p1) begin
          acc_q     <= '0;
          ovf_int_q <= 1'b0;
          act_q     <= 1'b0;
        end else begin
          acc_q     <= acc_next_p1;
          ovf_int_q <= ovf_int_q | ov_p1;
          act_q     <= 1'b1;
        end
      end
      // Stage 2 -> 3: requantised output register
      if (vld_p2) begin
        out_valid_q <= 1'b1;
        y_q         <= requant(acc_p2, shift_p2);
        acc_out_q   <= acc_p2;
        ovf_q       <= ovf_p2;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      if (accept) begin
        p_p1     <= prod_p0;
        last_p1  <= in_last;
        shift_p1 <= shift;
      end
      if (vld_p1 && last_p1) begin
        acc_p2   <= acc_next_p1;
        ovf_p2   <= ovf_int_q | ov_p1;
        shift_p2 <= shift_p1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_mac.sv
// Directed bench for pe_mac: a default instance and an ACC_WIDTH=16 instance share stimulus.
module tb_pe_mac;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_last, out_ready;
  logic [7:0]  w, x;
  logic [4:0]  shift;
  logic        in_ready, out_valid, ovf;
  logic [7:0]  y;
  logic [31:0] acc_out;
  logic        in_ready16, out_valid16, ovf16;
  logic [7:0]  y16;
  logic [15:0] acc16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_mac dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .w(w), .x(x), .in_last(in_last), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .acc_out(acc_out), .ovf(ovf)
  );

  pe_mac #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .w(w), .x(x), .in_last(in_last), .shift(shift), .out_valid(out_valid16),
    .out_ready(out_ready), .y(y16), .acc_out(acc16), .ovf(ovf16)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int wv, input int xv, input bit lst, input int sh);
    in_valid = 1'b1;
    w        = 8'(wv);
    x        = 8'(xv);
    in_last  = lst;
    shift    = 5'(sh);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, longint'(out_valid), 1);
  endtask

  task automatic consume();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    w = '0; x = '0; shift = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_y", longint'($signed(y)), 0);
    check("rst_acc_out", longint'($signed(acc_out)), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    // Reset pulse mid dot product discards partial sums
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("t1_out_valid", longint'(out_valid), 0);
    check("t1_y", longint'($signed(y)), 0);
    check("t1_acc_out", longint'($signed(acc_out)), 0);
    beat(2, 3, 1, 0);
    wait_res("t1");
    check("t1_y_new", longint'($signed(y)), 6);
    check("t1_acc_new", longint'($signed(acc_out)), 6);
    consume();

    // Four-beat dot product and its latency
    beat(1, 5, 0, 0);
    beat(2, 6, 0, 0);
    beat(3, 7, 0, 0);
    beat(4, 8, 1, 0);
    @(negedge clk);
    check("t2_lat0", longint'(out_valid), 0);
    @(negedge clk);
    check("t2_lat1", longint'(out_valid), 0);
    @(negedge clk);
    check("t2_lat2", longint'(out_valid), 1);
    check("t2_y", longint'($signed(y)), 70);
    check("t2_acc", longint'($signed(acc_out)), 70);
    check("t2_ovf", longint'(ovf), 0);
    consume();
    @(negedge clk);
    check("t2_drop", longint'(out_valid), 0);

    // Rounding, shifting and saturation
    beat(-128, -128, 1, 7);
    wait_res("t3a");
    check("t3a_acc", longint'($signed(acc_out)), 16384);
    check("t3a_y", longint'($signed(y)), 127);
    consume();
    beat(-128, -128, 1, 8);
    wait_res("t3b");
    check("t3b_y", longint'($signed(y)), 64);
    consume();
    beat(3, 1, 1, 1);
    wait_res("t3c");
    check("t3c_y", longint'($signed(y)), 2);
    consume();
    beat(-3, 1, 1, 1);
    wait_res("t3d");
    check("t3d_y", longint'($signed(y)), -1);
    consume();

    // Backpressure: result held, input blocked, nothing lost
    out_ready = 1'b0;
    beat(1, 5, 0, 0);
    beat(2, 6, 0, 0);
    beat(3, 7, 0, 0);
    beat(4, 8, 1, 0);
    wait_res("t4");
    in_valid = 1'b1; w = 8'(2); x = 8'(-4); in_last = 1'b1; shift = '0;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready", longint'(in_ready), 0);
      check("t4_out_valid", longint'(out_valid), 1);
      check("t4_y_hold", longint'($signed(y)), 70);
      check("t4_acc_hold", longint'($signed(acc_out)), 70);
      @(negedge clk);
    end
    check("t4_in_ready16", longint'(in_ready16), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("t4_drop", longint'(out_valid), 0);
    wait_res("t4n");
    check("t4n_y", longint'($signed(y)), -8);
    check("t4n_acc", longint'($signed(acc_out)), -8);
    consume();

    // Accumulator saturation on the 16-bit instance
    beat(127, 127, 0, 8);
    beat(127, 127, 0, 8);
    beat(127, 127, 1, 8);
    wait_res("t5");
    check("t5_valid16", longint'(out_valid16), 1);
    check("t5_acc16", longint'($signed(acc16)), 32767);
    check("t5_ovf16", longint'(ovf16), 1);
    check("t5_y16", longint'($signed(y16)), 127);
    check("t5_acc32", longint'($signed(acc_out)), 48387);
    check("t5_ovf32", longint'(ovf), 0);
    check("t5_y32", longint'($signed(y)), 127);
    consume();
    beat(1, 1, 1, 0);
    wait_res("t5n");
    check("t5n_ovf16", longint'(ovf16), 0);
    check("t5n_y16", longint'($signed(y16)), 1);
    consume();

    // Clear with a last beat in flight and a result on the output
    beat(5, 5, 1, 0);
    @(posedge clk); #1;
    beat(1, 2, 1, 0);
    clear = 1'b1;
    @(negedge clk);
    check("t6_pre_valid", longint'(out_valid), 1);
    check("t6_pre_y", longint'($signed(y)), 25);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("t6_out_valid", longint'(out_valid), 0);
    check("t6_ovf", longint'(ovf), 0);
    check("t6_y_kept", longint'($signed(y)), 25);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_result", longint'(seen), 0);
    beat(1, 1, 1, 0);
    wait_res("t6n");
    check("t6n_y", longint'($signed(y)), 1);
    check("t6n_acc", longint'($signed(acc_out)), 1);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
